// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: address and twiddle-index sequencer for a two-butterfly radix-2
// Cooley-Tukey NTT pass over N = 2^LOGN coefficients.
//
// A start pulse launches LOGN stages of N/4 issue cycles each. Every enabled issue
// cycle presents one butterfly per unit: unit 0 handles k = 2c, unit 1 handles
// k = 2c+1. STAGE_GAP enabled idle cycles are inserted between stages.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              single-cycle launch pulse (ignored while busy)
//   en                 advance enable; low freezes the sequence
//   busy               transform in progress (RUN or GAP)
//   valid              addresses and twiddles meaningful this cycle
//   done               one-cycle pulse after the final issue
//   stage              current stage index
//   addr_a0/addr_b0    upper/lower operand address, unit 0
//   addr_a1/addr_b1    upper/lower operand address, unit 1
//   tw0/tw1            twiddle ROM index, units 0 and 1
module ntt_addr_gen #(
  parameter int unsigned LOGN      = 8,
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            en,
  output logic            busy,
  output logic            valid,
  output logic            done,
  output logic [3:0]      stage,
  output logic [LOGN-1:0] addr_a0,
  output logic [LOGN-1:0] addr_b0,
  output logic [LOGN-1:0] addr_a1,
  output logic [LOGN-1:0] addr_b1,
  output logic [LOGN-1:0] tw0,
  output logic [LOGN-1:0] tw1
);

  localparam int unsigned     CW        = LOGN - 2;
  localparam logic [3:0]      LastStage = 4'(LOGN - 1);
  localparam logic [3:0]      GapLast   = 4'(STAGE_GAP - 1);
  localparam logic [LOGN-1:0] One       = LOGN'(1);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e          state_q;
  logic [3:0]      s_q;
  logic [CW-1:0]   c_q;
  logic [3:0]      g_q;
  logic            done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      g_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            s_q     <= '0;
            c_q     <= '0;
            g_q     <= '0;
          end
        end
        StRun: begin
          if (en) begin
            if (&c_q) begin
              c_q <= '0;
              if (s_q == LastStage) begin
                state_q <= StIdle;
                s_q     <= '0;
                done_q  <= 1'b1;
              end else begin
                // Stage advances now so GAP already shows the next stage index.
                s_q <= s_q + 4'd1;
                if (STAGE_GAP != 0) begin
                  state_q <= StGap;
                  g_q     <= '0;
                end
              end
            end else begin
              c_q <= c_q + CW'(1);
            end
          end
        end
        StGap: begin
          if (en) begin
            if (g_q == GapLast) begin
              state_q <= StRun;
              g_q     <= '0;
            end else begin
              g_q <= g_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Butterfly k in stage s, with span L = 2^(LOGN-1-s):
  //   a = group*2L + off, b = a + L, tw = 2^s + group.
  // group*2L is a shift; off occupies bits below L so OR equals the addition.
  function automatic logic [3*LOGN-1:0] bfly(input logic [LOGN-1:0] k, input logic [3:0] s);
    logic [3:0]      sh;
    logic [LOGN-1:0] span, grp, off, a;
    sh   = LastStage - s;
    span = One << sh;
    grp  = k >> sh;
    off  = k & (span - One);
    a    = ((grp << sh) << 1) | off;
    return {a, a | span, (One << s) + grp};
  endfunction

  logic [LOGN-1:0] k0, k1;
  logic            run;

  assign k0  = {1'b0, c_q, 1'b0};
  assign k1  = {1'b0, c_q, 1'b1};
  assign run = (state_q == StRun);

  always_comb begin
    {addr_a0, addr_b0, tw0} = '0;
    {addr_a1, addr_b1, tw1} = '0;
    if (run) begin
      {addr_a0, addr_b0, tw0} = bfly(k0, s_q);
      {addr_a1, addr_b1, tw1} = bfly(k1, s_q);
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = run & en;
  assign done  = done_q;
  assign stage = s_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
module tb_ntt_addr_gen;

  typedef struct {
    int s;
    int a0;
    int b0;
    int a1;
    int b1;
    int t0;
    int t1;
  } iss_t;

  logic clk;
  int   n_pass  = 0;
  int   n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input int inst, input bit ok, input string name,
                                input string act, input string exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL i%0d %s: got %s required %s", inst, name, act, exp);
  endfunction

  // Reference butterfly from the arithmetic definition (division / modulo).
  function automatic void bfly_model(input int lg, input int s, input int k,
                                     output int a, output int b, output int tw);
    int span, grp;
    span = 1 << (lg - 1 - s);
    grp  = k / span;
    a    = grp * 2 * span + (k % span);
    b    = a + span;
    tw   = (1 << s) + grp;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int LG   = (gi == 2) ? 8 : 3;
    localparam int GP   = (gi == 0) ? 0 : ((gi == 1) ? 2 : 4);
    localparam int NN   = 1 << LG;
    localparam int BASE = LG * NN / 4 + (LG - 1) * GP;

    logic          rstn, start, en, busy, valid, done;
    logic [3:0]    stage;
    logic [LG-1:0] a0, b0, a1, b1, t0, t1;
    iss_t          sb[$];
    bit            exp_done;
    bit            fin;

    ntt_addr_gen #(.LOGN(LG), .STAGE_GAP(GP)) u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
      .en      (en),
      .busy    (busy),
      .valid   (valid),
      .done    (done),
      .stage   (stage),
      .addr_a0 (a0),
      .addr_b0 (b0),
      .addr_a1 (a1),
      .addr_b1 (b1),
      .tw0     (t0),
      .tw1     (t1)
    );

    function automatic void push_run();
      iss_t e;
      int   a, b, t;
      for (int s = 0; s < LG; s++) begin
        for (int c = 0; c < NN / 4; c++) begin
          e.s = s;
          bfly_model(LG, s, 2 * c, a, b, t);
          e.a0 = a; e.b0 = b; e.t0 = t;
          bfly_model(LG, s, 2 * c + 1, a, b, t);
          e.a1 = a; e.b1 = b; e.t1 = t;
          sb.push_back(e);
        end
      end
    endfunction

    function automatic void check_zero(input string name);
      bit ok;
      ok = !busy && !valid && !done && stage == 0 && a0 == 0 && b0 == 0 && a1 == 0 &&
           b1 == 0 && t0 == 0 && t1 == 0;
      check(gi, ok, name,
            $sformatf("b%0d v%0d d%0d s%0d %0d %0d %0d %0d %0d %0d", busy, valid, done,
                      stage, a0, b0, a1, b1, t0, t1), "all zero");
    endfunction

    // Monitor: pops the scoreboard on every valid cycle.
    always @(negedge clk) begin
      iss_t e;
      if (rstn) begin
        if (valid) begin
          if (sb.size() == 0) begin
            check(gi, 1'b0, "unexpected_issue", "valid", "no issue");
          end else begin
            e = sb.pop_front();
            check(gi, stage == e.s && a0 == e.a0 && b0 == e.b0 && a1 == e.a1 && b1 == e.b1 &&
                  t0 == e.t0 && t1 == e.t1, "issue",
                  $sformatf("s%0d (%0d,%0d,%0d,%0d,%0d,%0d)", stage, a0, b0, a1, b1, t0, t1),
                  $sformatf("s%0d (%0d,%0d,%0d,%0d,%0d,%0d)", e.s, e.a0, e.b0, e.a1, e.b1,
                            e.t0, e.t1));
          end
        end else if (busy && sb.size() > 0) begin
          check(gi, stage == sb[0].s, "idle_stage", $sformatf("%0d", stage),
                $sformatf("%0d", sb[0].s));
        end
        if (!en) check(gi, !valid, "valid_when_en_low", $sformatf("%0d", valid), "0");
        if (done) begin
          check(gi, exp_done, "done_expected", "done=1", "no done");
          check(gi, sb.size() == 0, "done_after_all_issues", $sformatf("%0d left", sb.size()),
                "0 left");
          check(gi, !busy, "busy_low_at_done", $sformatf("%0d", busy), "0");
          exp_done = 1'b0;
        end
      end
    end

    task automatic do_run(input bit pre, input bit stalls, input bit rep, input bit chain);
      int stall_n = 0, vcnt = 0, gcnt = 0, done_cyc = 0, rep_cyc;
      rep_cyc = $urandom_range(2, BASE - 1);
      if (!pre) begin
        @(posedge clk); #1;
        push_run();
        exp_done = 1'b1;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      en = 1'b1;
      for (int cyc = 1; cyc <= BASE + BASE / 2 + 8; cyc++) begin
        @(negedge clk);
        if (cyc == 1) begin
          check(gi, busy, "busy_after_start", $sformatf("%0d", busy), "1");
          check(gi, valid == en, "first_valid", $sformatf("%0d", valid), $sformatf("%0d", en));
        end
        if (done) begin
          done_cyc = cyc;
          break;
        end
        if (valid) vcnt++;
        else if (busy && en) gcnt++;
        @(posedge clk); #1;
        start = rep && (cyc + 1 == rep_cyc);
        en = 1'b1;
        if (stalls && cyc + 1 <= BASE / 2) begin
          en = ($urandom_range(0, 3) != 0);
          if (!en) stall_n++;
        end
      end
      check(gi, done_cyc == BASE + stall_n + 1, "done_cycle", $sformatf("%0d", done_cyc),
            $sformatf("%0d", BASE + stall_n + 1));
      check(gi, vcnt == LG * NN / 4, "valid_count", $sformatf("%0d", vcnt),
            $sformatf("%0d", LG * NN / 4));
      check(gi, gcnt == (LG - 1) * GP, "gap_count", $sformatf("%0d", gcnt),
            $sformatf("%0d", (LG - 1) * GP));
      en = 1'b1;
      if (chain) begin
        #1;
        push_run();
        exp_done = 1'b1;
        start = 1'b1;
      end
    endtask

    initial begin
      fin = 1'b0;
      exp_done = 1'b0;
      rstn = 1'b0;
      start = 1'b0;
      en = 1'b1;
      #3;
      check_zero("reset_state");
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("idle_state");

      do_run(1'b0, 1'b0, 1'b1, 1'b1);  // start re-pulsed while busy, start in done cycle
      do_run(1'b1, 1'b1, 1'b0, 1'b0);  // chained start, random en stalls

      // Reset inside stage 1.
      @(posedge clk); #1;
      push_run();
      exp_done = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (NN / 4 + GP + 2) @(negedge clk);
      check(gi, busy && valid && stage == 1, "in_stage1",
            $sformatf("b%0d v%0d s%0d", busy, valid, stage), "b1 v1 s1");
      #1;
      rstn = 1'b0;
      sb.delete();
      exp_done = 1'b0;
      #1;
      check_zero("async_reset");
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check(gi, !done && !busy, "no_done_in_reset", $sformatf("d%0d b%0d", done, busy),
              "d0 b0");
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      do_run(1'b0, 1'b0, 1'b0, 1'b0);
      check(gi, sb.size() == 0, "scoreboard_empty", $sformatf("%0d", sb.size()), "0");
      fin = 1'b1;
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 20000 && !all_fin; i++) begin
      @(posedge clk);
      all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin;
    end
    check(99, all_fin, "completion", all_fin ? "finished" : "timeout", "finished");
    #20;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
